error_frame_tx: RTL and testbench

Transmit side of the CAN error-signalling path: on request from the protocol controller, drives an error flag onto the bus, then waits for the bus to go recessive and completes the error delimiter. Sits between the controller's error logic and the bit-level TX mux, on the same bit strobes and sample pulses used by the receive-side error-frame detector. It monitors bus readback to detect the end of flag superposition, delimiter violations and stuck-dominant conditions.

---
 rtl/error_frame_tx_pkg.sv | 31 +++
 rtl/error_frame_tx_sample_vote.sv | 85 ++++++++
 rtl/error_frame_tx.sv | 184 ++++++++++++++++++
 tb/tb_error_frame_tx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/error_frame_tx_pkg.sv
// Shared definitions for the CAN error-frame transmit and receive paths:
// state and sample-phase encodings, default frame constants, vote helper.
package error_frame_tx_pkg;

    localparam int CAN_ERR_FLAG_BITS  = 6;
    localparam int CAN_ERR_DELIM_BITS = 8;
    localparam int CAN_STUCK_FIRST    = 14;
    localparam int CAN_STUCK_NEXT     = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FLAG,
        WAIT_REC,
        DELIM
    } errTxState_t;

    // Where the sampler is inside the current bit time. PH_DONE means the
    // bit value has already been produced and further pulses are ignored.
    typedef enum logic [1:0] {
        PH_FIRST,
        PH_SECOND,
        PH_THIRD,
        PH_DONE
    } samplePhase_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/error_frame_tx_sample_vote.sv
// Per-bit bus sampler: counts sample-point pulses within a bit time, takes
// either the single sample or a 3-sample majority, and emits a registered
// one-cycle sampleValid together with the resolved bit value.
module sample_vote
    import error_frame_tx_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_bitStrobe,
    input  logic i_samplePulse,
    input  logic i_rateSelector,
    input  logic i_dIn,
    output logic o_sampleValid,
    output logic o_bitValue
);

    samplePhase_t r_phase;
    samplePhase_t w_phase;
    samplePhase_t w_phaseNext;
    logic         r_first;
    logic         r_second;
    logic         r_valid;
    logic         r_value;
    logic         w_first;
    logic         w_second;
    logic         w_valid;
    logic         w_value;

    // A strobe restarts the bit before the pulse in the same cycle is
    // considered, so a coincident pulse becomes sample 1 of the new bit.
    always_comb begin
        w_phase     = i_bitStrobe ? PH_FIRST : r_phase;
        w_phaseNext = w_phase;
        w_first     = r_first;
        w_second    = r_second;
        w_valid     = 1'b0;
        w_value     = r_value;
        if (i_samplePulse) begin
            case (w_phase)
                PH_FIRST: begin
                    w_first = i_dIn;
                    if (i_rateSelector) begin
                        w_phaseNext = PH_SECOND;
                    end else begin
                        w_phaseNext = PH_DONE;
                        w_valid     = 1'b1;
                        w_value     = i_dIn;
                    end
                end
                PH_SECOND: begin
                    w_second    = i_dIn;
                    w_phaseNext = PH_THIRD;
                end
                PH_THIRD: begin
                    w_phaseNext = PH_DONE;
                    w_valid     = 1'b1;
                    w_value     = majority3(r_first, r_second, i_dIn);
                end
                default: begin
                end
            endcase
        end
    end

    // Sample storage and the registered valid/value pair.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase  <= PH_FIRST;
            r_first  <= 1'b1;
            r_second <= 1'b1;
            r_valid  <= 1'b0;
            r_value  <= 1'b1;
        end else begin
            r_phase  <= w_phaseNext;
            r_first  <= w_first;
            r_second <= w_second;
            r_valid  <= w_valid;
            r_value  <= w_value;
        end
    end

    assign o_sampleValid = r_valid;
    assign o_bitValue    = r_value;

endmodule

// File: rtl/error_frame_tx.sv
// CAN error-frame transmitter: drives the error flag on request, waits for
// the bus to go recessive after flag superposition, then counts out the
// delimiter, flagging stuck-dominant buses and delimiter bit errors.
module error_frame_tx
    import error_frame_tx_pkg::*;
#(
    parameter int FLAG_BITS   = CAN_ERR_FLAG_BITS,
    parameter int DELIM_BITS  = CAN_ERR_DELIM_BITS,
    parameter int STUCK_FIRST = CAN_STUCK_FIRST,
    parameter int STUCK_NEXT  = CAN_STUCK_NEXT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_txStart,
    input  logic i_errorPassive,
    input  logic i_bitStrobe,
    input  logic i_samplePulse,
    input  logic i_rateSelector,
    input  logic i_dIn,
    output logic o_txOut,
    output logic o_busy,
    output logic o_done,
    output logic o_stuckDominant,
    output logic o_bitError
);

    errTxState_t r_state;
    errTxState_t w_state;
    logic [2:0]  r_bitCnt;
    logic [2:0]  w_bitCnt;
    logic [3:0]  r_delimCnt;
    logic [3:0]  w_delimCnt;
    logic [4:0]  r_domCnt;
    logic [4:0]  w_domCnt;
    logic [4:0]  w_domInc;
    logic        r_passive;
    logic        w_passive;
    logic        r_txOut;
    logic        w_txOut;
    logic        r_busy;
    logic        w_busy;
    logic        r_done;
    logic        w_done;
    logic        r_stuck;
    logic        w_stuck;
    logic        r_bitError;
    logic        w_bitError;
    logic        w_sampleValid;
    logic        w_bitValue;

    sample_vote u_sampleVote (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_bitStrobe    (i_bitStrobe),
        .i_samplePulse  (i_samplePulse),
        .i_rateSelector (i_rateSelector),
        .i_dIn          (i_dIn),
        .o_sampleValid  (w_sampleValid),
        .o_bitValue     (w_bitValue)
    );

    // Next-state and next-output logic. After the first stuck threshold the
    // dominant counter is folded back by STUCK_NEXT at each later threshold,
    // so pulses keep coming every STUCK_NEXT bits without the counter ever
    // reaching its saturation point; saturation remains as a safety net.
    always_comb begin
        w_state    = r_state;
        w_bitCnt   = r_bitCnt;
        w_delimCnt = r_delimCnt;
        w_domCnt   = r_domCnt;
        w_passive  = r_passive;
        w_txOut    = r_txOut;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_stuck    = 1'b0;
        w_bitError = 1'b0;
        w_domInc   = (r_domCnt == 5'd31) ? r_domCnt : r_domCnt + 5'd1;
        case (r_state)
            IDLE: begin
                w_txOut = 1'b1;
                if (i_txStart && !r_done) begin
                    w_passive = i_errorPassive;
                    w_state   = ARM;
                    w_busy    = 1'b1;
                end
            end
            ARM: begin
                if (i_bitStrobe) begin
                    w_state  = FLAG;
                    w_bitCnt = 3'd1;
                    w_txOut  = r_passive;
                end
            end
            FLAG: begin
                if (i_bitStrobe) begin
                    if (r_bitCnt == 3'(FLAG_BITS)) begin
                        w_state  = WAIT_REC;
                        w_txOut  = 1'b1;
                        w_bitCnt = 3'd0;
                        w_domCnt = 5'd0;
                    end else begin
                        w_bitCnt = r_bitCnt + 3'd1;
                    end
                end
            end
            WAIT_REC: begin
                w_txOut = 1'b1;
                if (w_sampleValid) begin
                    if (w_bitValue) begin
                        w_state    = DELIM;
                        w_delimCnt = 4'd1;
                        w_domCnt   = 5'd0;
                    end else begin
                        w_domCnt = w_domInc;
                        if (w_domInc == 5'(STUCK_FIRST)) begin
                            w_stuck = 1'b1;
                        end else if (w_domInc == 5'(STUCK_FIRST + STUCK_NEXT)) begin
                            w_stuck  = 1'b1;
                            w_domCnt = 5'(STUCK_FIRST);
                        end
                    end
                end
            end
            DELIM: begin
                w_txOut = 1'b1;
                if (w_sampleValid) begin
                    if (w_bitValue) begin
                        if (r_delimCnt + 4'd1 == 4'(DELIM_BITS)) begin
                            w_state    = IDLE;
                            w_done     = 1'b1;
                            w_busy     = 1'b0;
                            w_delimCnt = 4'd0;
                        end else begin
                            w_delimCnt = r_delimCnt + 4'd1;
                        end
                    end else begin
                        w_state    = ARM;
                        w_bitError = 1'b1;
                        w_delimCnt = 4'd0;
                    end
                end
            end
            default: begin
                w_state = IDLE;
                w_txOut = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_bitCnt   <= 3'd0;
            r_delimCnt <= 4'd0;
            r_domCnt   <= 5'd0;
            r_passive  <= 1'b0;
            r_txOut    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_stuck    <= 1'b0;
            r_bitError <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_bitCnt   <= w_bitCnt;
            r_delimCnt <= w_delimCnt;
            r_domCnt   <= w_domCnt;
            r_passive  <= w_passive;
            r_txOut    <= w_txOut;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_stuck    <= w_stuck;
            r_bitError <= w_bitError;
        end
    end

    assign o_txOut         = r_txOut;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_stuckDominant = r_stuck;
    assign o_bitError      = r_bitError;

endmodule

// File: tb/tb_error_frame_tx.sv
// Bench for error_frame_tx: bit-timed stimulus (10 cycles per bit, strobe at
// cycle 0, samples at cycles 5-7) with a scoreboard of expected per-bit line
// levels and expected pulse events tagged with the bit they belong to.
module tb_error_frame_tx;

    logic clk = 1'b0;
    logic reset;
    logic txStart;
    logic errorPassive;
    logic bitStrobe;
    logic samplePulse;
    logic rateSelector;
    logic busExt;
    logic dIn;
    logic o_txOut;
    logic o_busy;
    logic o_done;
    logic o_stuckDominant;
    logic o_bitError;

    int checks = 0;
    int errors = 0;
    int bitNum = 0;
    bit startOnDone = 1'b0;
    int evQ[$];
    logic [1:0] bitQ[$];

    // Wired-AND bus: our driver plus any external dominant node.
    assign dIn = o_txOut & busExt;

    always #5 clk = ~clk;

    error_frame_tx dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_txStart      (txStart),
        .i_errorPassive (errorPassive),
        .i_bitStrobe    (bitStrobe),
        .i_samplePulse  (samplePulse),
        .i_rateSelector (rateSelector),
        .i_dIn          (dIn),
        .o_txOut        (o_txOut),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_stuckDominant(o_stuckDominant),
        .o_bitError     (o_bitError)
    );

    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Event codes: kind*100 + bit number (1=done, 2=stuckDominant, 3=bitError).
    task popEvent(input string tag, input int observed);
        if (evQ.size() == 0) checkOutput({tag, "Unexpected"}, observed, 0);
        else checkOutput(tag, observed, evQ.pop_front());
    endtask

    // One clock: compare any pulse against the scoreboard, then drive inputs.
    task applyStimulus(input logic strobe, input logic sample);
        @(negedge clk);
        if (o_done !== 1'b0) begin
            popEvent("done", 100 + bitNum);
            checkOutput("busyAtDone", o_busy, 0);
        end
        if (o_stuckDominant !== 1'b0) popEvent("stuck", 200 + bitNum);
        if (o_bitError !== 1'b0) popEvent("bitError", 300 + bitNum);
        txStart     = startOnDone && (o_done === 1'b1);
        bitStrobe   = strobe;
        samplePulse = sample;
    endtask

    task runBit(input logic extDom);
        logic [1:0] exp;
        bitNum++;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(c == 0, (c >= 5) && (c <= 7));
            if (c == 0) busExt = !extDom;
            if (c == 3) begin
                exp = bitQ.pop_front();
                checkOutput($sformatf("txOutBit%0d", bitNum), o_txOut, exp[1]);
                checkOutput($sformatf("busyBit%0d", bitNum), o_busy, exp[0]);
            end
        end
    endtask

    task startFrame(input logic passive, input logic rate);
        applyStimulus(1'b0, 1'b0);
        txStart      = 1'b1;
        errorPassive = passive;
        rateSelector = rate;
        bitNum       = 0;
    endtask

    // Plays a whole frame. Expected drive is dominant only inside active
    // flag windows (bits 1-6 and, after a delimiter error, flag2..flag2+5).
    task playFrame(input string name, input logic passive, input logic rate,
                   input int domFrom, input int domTo, input int flag2, input int totalBits);
        logic inFlag;
        startFrame(passive, rate);
        for (int b = 1; b <= totalBits; b++) begin
            inFlag = (b <= 6) || ((flag2 > 0) && (b >= flag2) && (b < flag2 + 6));
            bitQ.push_back({passive ? 1'b1 : !inFlag, 1'b1});
            runBit((b >= domFrom) && (b <= domTo));
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
        checkOutput({name, "EventsLeft"}, evQ.size(), 0);
        checkOutput({name, "IdleBusy"}, o_busy, 0);
        checkOutput({name, "IdleTxOut"}, o_txOut, 1);
        evQ.delete();
    endtask

    initial begin
        reset        = 1'b1;
        txStart      = 1'b0;
        errorPassive = 1'b0;
        bitStrobe    = 1'b0;
        samplePulse  = 1'b0;
        rateSelector = 1'b1;
        busExt       = 1'b1;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("resetTxOut", o_txOut, 1);
        checkOutput("resetBusy", o_busy, 0);
        checkOutput("resetDone", o_done, 0);
        checkOutput("resetStuck", o_stuckDominant, 0);
        checkOutput("resetBitError", o_bitError, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);

        // Active frame on an idle bus; a txStart during the done cycle is dropped.
        evQ.push_back(100 + 14);
        startOnDone = 1'b1;
        playFrame("active", 1'b0, 1'b1, 100, 0, 0, 14);
        startOnDone = 1'b0;

        // Passive flag: line stays recessive.
        evQ.push_back(100 + 14);
        playFrame("passive", 1'b1, 1'b1, 100, 0, 0, 14);

        // Single-sample mode, extra pulses in the bit ignored.
        evQ.push_back(100 + 14);
        playFrame("singleSample", 1'b0, 1'b0, 100, 0, 0, 14);

        // Superposition: 5 extra dominant bits after the flag.
        evQ.push_back(100 + 19);
        playFrame("superpos", 1'b0, 1'b1, 7, 11, 0, 19);

        // Stuck bus: 30 dominant bits after the flag.
        evQ.push_back(200 + 20);
        evQ.push_back(200 + 28);
        evQ.push_back(200 + 36);
        evQ.push_back(100 + 44);
        playFrame("stuck", 1'b0, 1'b1, 7, 36, 0, 44);

        // Delimiter violation on delimiter bit 4 (frame bit 10).
        evQ.push_back(300 + 10);
        evQ.push_back(100 + 24);
        playFrame("delimErr", 1'b0, 1'b1, 10, 10, 11, 24);

        // Reset during flag bit 3, then a full normal frame.
        startFrame(1'b0, 1'b1);
        for (int b = 1; b <= 2; b++) begin
            bitQ.push_back(2'b01);
            runBit(1'b0);
        end
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("flagBeforeReset", o_txOut, 0);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("resetMidTxOut", o_txOut, 1);
        checkOutput("resetMidBusy", o_busy, 0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("afterResetEvents", evQ.size(), 0);
        evQ.push_back(100 + 14);
        playFrame("postReset", 1'b0, 1'b1, 100, 0, 0, 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
